// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - execute-bundle, RAM and write-back signals of the memory stage
// Signals:
//   ex_valid/in_ready              - execute bundle handshake
//   ins_type, ins_details, rd_addr,
//   rd_val, mem_addr, mem_val      - execute result bundle
//   ram_a, ram_wr, ram_dout,
//   ram_din                        - 8-bit RAM port (read data one cycle after address)
//   wb_valid, wb_rd_addr, wb_rd_val - write-back record to the register-file stage
// Modports: master = upstream/RAM side, slave = the memory stage.
interface mem_access_if #(
  parameter int RAM_ADDR_W = 32
);
  logic                  ex_valid;
  logic                  in_ready;
  logic [6:0]            ins_type;
  logic [2:0]            ins_details;
  logic [4:0]            rd_addr;
  logic [31:0]           rd_val;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_val;
  logic [RAM_ADDR_W-1:0] ram_a;
  logic                  ram_wr;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;
  logic                  wb_valid;
  logic [4:0]            wb_rd_addr;
  logic [31:0]           wb_rd_val;

  modport master (
    output ex_valid, ins_type, ins_details, rd_addr, rd_val, mem_addr, mem_val, ram_din,
    input  in_ready, ram_a, ram_wr, ram_dout, wb_valid, wb_rd_addr, wb_rd_val
  );

  modport slave (
    input  ex_valid, ins_type, ins_details, rd_addr, rd_val, mem_addr, mem_val, ram_din,
    output in_ready, ram_a, ram_wr, ram_dout, wb_valid, wb_rd_addr, wb_rd_val
  );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - byte-serial LOAD/SAVE memory stage of the EPU pipeline
// Ports:
//   clk_in - clock, all state on the rising edge
//   rst_in - asynchronous active-low reset
//   bus    - mem_access_if.slave: execute bundle in, 8-bit RAM port, write-back out
module mem_access #(
  parameter int RAM_ADDR_W = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  mem_access_if.slave bus
);
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_SAVE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_t;
  state_t state, state_d;

  logic [2:0]  det_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q;
  logic [31:0] val_q;
  logic [31:0] data_q;
  logic [2:0]  k;
  logic [2:0]  n;
  logic        accept;
  logic        last;
  logic [31:0] ram_a_full;
  logic        ram_wr_c;
  logic [7:0]  ram_dout_c;
  logic [1:0]  lane;
  logic [31:0] word_c;
  logic [31:0] ext_c;
  logic        sx;

  assign accept       = bus.ex_valid && (state == S_IDLE);
  assign n            = det_q[1] ? 3'd4 : (det_q[0] ? 3'd2 : 3'd1);
  // In LOAD, the byte arriving in step k was addressed in step k-1.
  assign lane         = k[1:0] - 2'd1;
  assign bus.in_ready = (state == S_IDLE);
  assign bus.ram_a    = ram_a_full[RAM_ADDR_W-1:0];
  assign bus.ram_wr   = ram_wr_c;
  assign bus.ram_dout = ram_dout_c;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d    = state;
    last       = 1'b0;
    ram_a_full = 32'h0;
    ram_wr_c   = 1'b0;
    ram_dout_c = 8'h00;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bus.ins_type == OP_LOAD)      state_d = S_LOAD;
          else if (bus.ins_type == OP_SAVE) state_d = S_STORE;
        end
      end
      S_LOAD: begin
        // Steps 0..N-1 issue addresses; step N only collects the final byte.
        if (k < n) ram_a_full = addr_q + {29'd0, k};
        if (k == n) begin
          last    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STORE: begin
        ram_a_full = addr_q + {29'd0, k};
        ram_wr_c   = 1'b1;
        ram_dout_c = val_q[{k[1:0], 3'b000} +: 8];
        if (k == n - 3'd1) begin
          last    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Merge the byte arriving this cycle into the load word, then extend.
  always_comb begin
    word_c                        = data_q;
    word_c[{lane, 3'b000} +: 8]   = bus.ram_din;
    sx                            = ~det_q[2];
    case (det_q[1:0])
      2'b00:   ext_c = {{24{sx & word_c[7]}},  word_c[7:0]};
      2'b01:   ext_c = {{16{sx & word_c[15]}}, word_c[15:0]};
      default: ext_c = word_c;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      det_q          <= 3'd0;
      rd_q           <= 5'd0;
      addr_q         <= 32'h0;
      val_q          <= 32'h0;
      data_q         <= 32'h0;
      k              <= 3'd0;
      bus.wb_valid   <= 1'b0;
      bus.wb_rd_addr <= 5'd0;
      bus.wb_rd_val  <= 32'h0;
    end else begin
      bus.wb_valid <= 1'b0;
      if (accept) begin
        det_q  <= bus.ins_details;
        rd_q   <= bus.rd_addr;
        addr_q <= bus.mem_addr;
        val_q  <= bus.mem_val;
        data_q <= 32'h0;
        k      <= 3'd0;
        if (bus.ins_type != OP_LOAD && bus.ins_type != OP_SAVE) begin
          bus.wb_valid   <= 1'b1;
          bus.wb_rd_addr <= bus.rd_addr;
          bus.wb_rd_val  <= bus.rd_val;
        end
      end else if (state != S_IDLE) begin
        k <= k + 3'd1;
        if (state == S_LOAD && k != 3'd0) data_q <= word_c;
        if (last) begin
          bus.wb_valid   <= 1'b1;
          bus.wb_rd_addr <= (state == S_LOAD) ? rd_q  : 5'd0;
          bus.wb_rd_val  <= (state == S_LOAD) ? ext_c : 32'h0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access with a byte-addressed RAM model
module tb_mem_access;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_SAVE = 7'b0100011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_if #(.RAM_ADDR_W(32)) bus ();
  mem_access #(.RAM_ADDR_W(32)) dut (.clk_in(clk), .rst_in(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  // RAM seen by the DUT, and the bench's own expected memory image.
  logic [7:0] ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  logic [7:0] din_q = 8'h00;
  bit force_ff = 1'b0;

  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
    din_q <= ram.exists(bus.ram_a) ? ram[bus.ram_a] : 8'h00;
  end
  assign bus.ram_din = force_ff ? 8'hFF : din_q;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction
  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction
  function automatic int nbytes(input logic [2:0] d);
    return d[1] ? 4 : (d[0] ? 2 : 1);
  endfunction
  // Little-endian assembly, then two's-complement wrap when sign bit set.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] d);
    longint unsigned v = 0;
    int n = nbytes(d);
    for (int i = 0; i < n; i++) v += longint'(ref_byte(a + 32'(i))) << (8 * i);
    if (!d[2] && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction
  task automatic ref_store(input logic [31:0] a, input logic [2:0] d, input logic [31:0] v);
    for (int i = 0; i < nbytes(d); i++) ref_mem[a + 32'(i)] = v[8*i +: 8];
  endtask
  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  // Per-cycle observations after an accept edge (cycle 1 onwards).
  int          wb_cyc, wb_cnt;
  logic [4:0]  wb_addr;
  logic [31:0] wb_val;
  logic [31:0] o_a [1:12];
  logic        o_wr [1:12];
  logic [7:0]  o_dout [1:12];
  logic        o_rdy [1:12];

  task automatic issue(input logic [6:0] t, input logic [2:0] d, input logic [4:0] rd,
                       input logic [31:0] rv, input logic [31:0] ma, input logic [31:0] mv);
    bus.ex_valid = 1'b1; bus.ins_type = t; bus.ins_details = d; bus.rd_addr = rd;
    bus.rd_val = rv; bus.mem_addr = ma; bus.mem_val = mv;
    @(posedge clk);
    #1 bus.ex_valid = 1'b0;
  endtask

  task automatic observe(input int budget);
    wb_cyc = -1; wb_cnt = 0; wb_addr = '0; wb_val = '0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      o_a[c] = bus.ram_a; o_wr[c] = bus.ram_wr; o_dout[c] = bus.ram_dout; o_rdy[c] = bus.in_ready;
      if (bus.wb_valid) begin
        wb_cnt++;
        if (wb_cyc < 0) begin wb_cyc = c; wb_addr = bus.wb_rd_addr; wb_val = bus.wb_rd_val; end
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; force_ff = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.wb_valid !== 1'b0 || bus.wb_rd_addr !== 5'd0 || bus.wb_rd_val !== 32'h0) begin
      failures++; $display("FAIL reset_wb got=%b/%h/%h exp=0/0/0", bus.wb_valid, bus.wb_rd_addr, bus.wb_rd_val); end
    checks++; if (bus.ram_a !== 32'h0 || bus.ram_wr !== 1'b0 || bus.ram_dout !== 8'h00) begin
      failures++; $display("FAIL reset_ram got=%h/%b/%h exp=0/0/0", bus.ram_a, bus.ram_wr, bus.ram_dout); end
    force_ff = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) preload(32'h40 + 32'(i), 8'(8'h11 * (i + 1)));
    issue(OP_LOAD, 3'b010, 5'd7, 32'h0, 32'h40, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ram_a !== 32'h0 || bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_clear got=a:%h rdy:%b wb:%b exp=a:0 rdy:1 wb:0", bus.ram_a, bus.in_ready, bus.wb_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); if (bus.wb_valid) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_no_wb got=%0d exp=0", seen); end
  endtask

  task automatic test_nonmem_back_to_back();
    logic [31:0] v2;
    v2 = $urandom;
    bus.ex_valid = 1'b1; bus.ins_type = OP_ALU; bus.ins_details = 3'b000;
    bus.rd_addr = 5'd5; bus.rd_val = 32'h1234_5678; bus.mem_addr = $urandom; bus.mem_val = $urandom;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%b exp=1", bus.in_ready); end
    @(posedge clk);
    #1 bus.rd_addr = 5'd9; bus.rd_val = v2;
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd_addr !== 5'd5 || bus.wb_rd_val !== 32'h1234_5678) begin
      failures++; $display("FAIL b2b_wb1 got=%b/%0d/%h exp=1/5/12345678", bus.wb_valid, bus.wb_rd_addr, bus.wb_rd_val); end
    checks++; if (bus.in_ready !== 1'b1 || bus.ram_wr !== 1'b0) begin
      failures++; $display("FAIL b2b_ready1 got=%b/%b exp=1/0", bus.in_ready, bus.ram_wr); end
    @(posedge clk);
    #1 bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd_addr !== 5'd9 || bus.wb_rd_val !== v2) begin
      failures++; $display("FAIL b2b_wb2 got=%b/%0d/%h exp=1/9/%h", bus.wb_valid, bus.wb_rd_addr, bus.wb_rd_val, v2); end
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL b2b_pulse got=%b exp=0", bus.wb_valid); end
  endtask

  task automatic test_lw();
    preload(32'h100, 8'h78); preload(32'h101, 8'h56); preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    issue(OP_LOAD, 3'b010, 5'd3, 32'hDEAD_BEEF, 32'h100, 32'h0);
    observe(8);
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_a[1+i] !== 32'h100 + 32'(i) || o_wr[1+i] !== 1'b0) begin
        failures++; $display("FAIL lw_addr%0d got=%h/%b exp=%h/0", i, o_a[1+i], o_wr[1+i], 32'h100 + 32'(i)); end
    end
    checks++; if (wb_cyc !== 6 || wb_cnt !== 1) begin failures++; $display("FAIL lw_latency got=%0d/%0d exp=6/1", wb_cyc, wb_cnt); end
    checks++; if (wb_val !== 32'h1234_5678 || wb_addr !== 5'd3) begin
      failures++; $display("FAIL lw_value got=%h/%0d exp=12345678/3", wb_val, wb_addr); end
    checks++; if (o_rdy[5] !== 1'b0 || o_rdy[6] !== 1'b1) begin
      failures++; $display("FAIL lw_ready got=%b%b exp=01", o_rdy[5], o_rdy[6]); end
  endtask

  task automatic test_lb_lbu_lh();
    preload(32'h200, 8'h80);
    issue(OP_LOAD, 3'b000, 5'd1, 32'h0, 32'h200, 32'h0);
    observe(8);
    checks++; if (wb_cyc !== 3 || wb_val !== 32'hFFFF_FF80) begin
      failures++; $display("FAIL lb got=c%0d/%h exp=c3/ffffff80", wb_cyc, wb_val); end
    issue(OP_LOAD, 3'b100, 5'd2, 32'h0, 32'h200, 32'h0);
    observe(8);
    checks++; if (wb_cyc !== 3 || wb_val !== 32'h0000_0080) begin
      failures++; $display("FAIL lbu got=c%0d/%h exp=c3/00000080", wb_cyc, wb_val); end
    preload(32'h210, 8'h34); preload(32'h211, 8'hF2);
    issue(OP_LOAD, 3'b001, 5'd0, 32'h0, 32'h210, 32'h0);
    observe(8);
    checks++; if (wb_cyc !== 4 || wb_val !== 32'hFFFF_F234 || wb_addr !== 5'd0) begin
      failures++; $display("FAIL lh got=c%0d/%h/%0d exp=c4/fffff234/0", wb_cyc, wb_val, wb_addr); end
  endtask

  task automatic test_sh_wrap();
    issue(OP_SAVE, 3'b001, 5'd3, 32'h5555_5555, 32'hFFFF_FFFF, 32'hAABB_CCDD);
    observe(8);
    ref_store(32'hFFFF_FFFF, 3'b001, 32'hAABB_CCDD);
    checks++; if (o_a[1] !== 32'hFFFF_FFFF || o_wr[1] !== 1'b1 || o_dout[1] !== 8'hDD) begin
      failures++; $display("FAIL sh_byte0 got=%h/%b/%h exp=ffffffff/1/dd", o_a[1], o_wr[1], o_dout[1]); end
    checks++; if (o_a[2] !== 32'h0 || o_wr[2] !== 1'b1 || o_dout[2] !== 8'hCC) begin
      failures++; $display("FAIL sh_byte1 got=%h/%b/%h exp=0/1/cc", o_a[2], o_wr[2], o_dout[2]); end
    checks++; if (wb_cyc !== 3 || wb_addr !== 5'd0 || wb_val !== 32'h0) begin
      failures++; $display("FAIL sh_wb got=c%0d/%0d/%h exp=c3/0/0", wb_cyc, wb_addr, wb_val); end
    checks++; if (ram_byte(32'hFFFF_FFFF) !== 8'hDD || ram_byte(32'h0) !== 8'hCC) begin
      failures++; $display("FAIL sh_mem got=%h/%h exp=dd/cc", ram_byte(32'hFFFF_FFFF), ram_byte(32'h0)); end
  endtask

  task automatic test_sw_hold();
    logic [31:0] mv, rv2;
    int early;
    mv = $urandom; rv2 = $urandom; early = 0;
    bus.ex_valid = 1'b1; bus.ins_type = OP_SAVE; bus.ins_details = 3'b010; bus.rd_addr = 5'd4;
    bus.rd_val = $urandom; bus.mem_addr = 32'h301; bus.mem_val = mv;
    @(posedge clk);
    #1 bus.ins_type = OP_ALU; bus.rd_addr = 5'd11; bus.rd_val = rv2;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'(c == 5)) begin
        failures++; $display("FAIL sw_hold_ready c%0d got=%b exp=%b", c, bus.in_ready, c == 5); end
      if (c < 5 && bus.wb_valid) early++;
    end
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd_addr !== 5'd0 || bus.wb_rd_val !== 32'h0 || early !== 0) begin
      failures++; $display("FAIL sw_hold_wb got=%b/%0d/%h early=%0d exp=1/0/0 early=0",
                           bus.wb_valid, bus.wb_rd_addr, bus.wb_rd_val, early); end
    @(posedge clk);
    #1 bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd_addr !== 5'd11 || bus.wb_rd_val !== rv2) begin
      failures++; $display("FAIL sw_hold_second got=%b/%0d/%h exp=1/11/%h", bus.wb_valid, bus.wb_rd_addr, bus.wb_rd_val, rv2); end
    ref_store(32'h301, 3'b010, mv);
    for (int i = 0; i < 4; i++) begin
      checks++; if (ram_byte(32'h301 + 32'(i)) !== mv[8*i +: 8]) begin
        failures++; $display("FAIL sw_mem%0d got=%h exp=%h", i, ram_byte(32'h301 + 32'(i)), mv[8*i +: 8]); end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int kind, n, lat;
    logic [2:0] d;
    logic [4:0] rd;
    logic [31:0] a, mv, rv, exp_val;
    logic [6:0] t;
    for (int i = 0; i < 16; i++) begin
      preload(32'h1000 + 32'(i), 8'($urandom));
      preload(32'hFFFF_FFF8 + 32'(i), 8'($urandom));
    end
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      d = 3'($urandom); rd = 5'($urandom); rv = $urandom; mv = $urandom;
      a = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                      : 32'h1000 + 32'($urandom_range(0, 12));
      n = nbytes(d);
      t = (kind == 0) ? (($urandom_range(0, 1) == 1) ? OP_ALU : 7'b0010011) : ((kind == 1) ? OP_LOAD : OP_SAVE);
      lat = (kind == 0) ? 1 : ((kind == 1) ? n + 2 : n + 1);
      exp_val = (kind == 0) ? rv : ((kind == 1) ? ref_load(a, d) : 32'h0);
      issue(t, d, rd, rv, a, mv);
      observe(8);
      if (kind == 2) ref_store(a, d, mv);
      checks++; if (wb_cyc !== lat || wb_cnt !== 1) begin
        failures++; $display("FAIL rnd%0d_latency kind=%0d got=%0d/%0d exp=%0d/1", it, kind, wb_cyc, wb_cnt, lat); end
      checks++; if (wb_addr !== ((kind == 2) ? 5'd0 : rd) || wb_val !== exp_val) begin
        failures++; $display("FAIL rnd%0d_wb kind=%0d a=%h d=%b got=%0d/%h exp=%0d/%h",
                             it, kind, a, d, wb_addr, wb_val, (kind == 2) ? 5'd0 : rd, exp_val); end
      if (kind == 0) begin
        checks++; if (o_a[1] !== 32'h0 || o_wr[1] !== 1'b0 || o_rdy[1] !== 1'b1) begin
          failures++; $display("FAIL rnd%0d_alu_idle got=%h/%b/%b exp=0/0/1", it, o_a[1], o_wr[1], o_rdy[1]); end
      end else begin
        for (int k = 0; k < n; k++) begin
          checks++; if (o_a[1+k] !== a + 32'(k) || o_wr[1+k] !== 1'(kind == 2) ||
                        (kind == 2 && o_dout[1+k] !== mv[8*k +: 8])) begin
            failures++; $display("FAIL rnd%0d_ram%0d got=%h/%b/%h exp=%h/%b/%h", it, k, o_a[1+k], o_wr[1+k],
                                 o_dout[1+k], a + 32'(k), kind == 2, mv[8*k +: 8]); end
        end
        checks++; if (o_a[n+1] !== 32'h0 || o_wr[n+1] !== 1'b0) begin
          failures++; $display("FAIL rnd%0d_ram_quiet got=%h/%b exp=0/0", it, o_a[n+1], o_wr[n+1]); end
        for (int c = 1; c <= lat; c++) begin
          checks++; if (o_rdy[c] !== 1'(c == lat)) begin
            failures++; $display("FAIL rnd%0d_ready c%0d got=%b exp=%b", it, c, o_rdy[c], c == lat); end
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (ram_byte(32'h1000 + 32'(i)) !== ref_byte(32'h1000 + 32'(i)) ||
                    ram_byte(32'hFFFF_FFF8 + 32'(i)) !== ref_byte(32'hFFFF_FFF8 + 32'(i))) begin
        failures++; $display("FAIL rnd_mem%0d got=%h/%h exp=%h/%h", i, ram_byte(32'h1000 + 32'(i)),
                             ram_byte(32'hFFFF_FFF8 + 32'(i)), ref_byte(32'h1000 + 32'(i)), ref_byte(32'hFFFF_FFF8 + 32'(i))); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ex_valid = 1'b0; bus.ins_type = 7'd0; bus.ins_details = 3'd0; bus.rd_addr = 5'd0;
    bus.rd_val = 32'h0; bus.mem_addr = 32'h0; bus.mem_val = 32'h0;
    test_reset();
    test_nonmem_back_to_back();
    test_lw();
    test_lb_lbu_lh();
    test_sh_wrap();
    test_sw_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory stage of the EPU pipeline, consuming the execute stage's result bundle (`ins_type`, `ins_details`, `rd_addr`, `rd_val`, `mem_addr`, `mem_val`). It performs LOAD/SAVE instructions byte-serially over an 8-bit RAM port, sign- or zero-extends load data, and forwards a write-back record to the register-file stage. Non-memory instructions pass through with one cycle of latency. The stage stalls upstream through `in_ready` while a multi-byte access is in flight.

## Interface
- `RAM_ADDR_W`, default 32: width of `ram_a`. Byte addresses are truncated to this width.
- `clk_in` input 1: clock; all state updates on the rising edge.
- `rst_in` input 1: asynchronous, active-low reset.
- `ex_valid` input 1: execute bundle valid this cycle.
- `in_ready` output 1: stage can accept a bundle; high only in IDLE.
- `ins_type` input 7: opcode class. LOAD = 7'b0000011, SAVE = 7'b0100011; any other value is non-memory.
- `ins_details` input 3: funct3. Bits [1:0] give size (00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes); bit [2] = 1 selects zero-extension.
- `rd_addr` input 5: destination register.
- `rd_val` input 32: ALU result, forwarded unchanged for non-memory instructions.
- `mem_addr` input 32: effective byte address.
- `mem_val` input 32: store data.
- `ram_a` output RAM_ADDR_W: RAM byte address.
- `ram_wr` output 1: 1 = write `ram_dout` at `ram_a`.
- `ram_dout` output 8: write data byte.
- `ram_din` input 8: read data. It is valid one cycle after the address is presented with `ram_wr` = 0.
- `wb_valid` output 1: one-cycle pulse marking a retired instruction.
- `wb_rd_addr` output 5: write-back register. It is 0 for SAVE.
- `wb_rd_val` output 32: write-back value. It is 0 for SAVE.

## Operation
- FSM states and transitions:
  - IDLE: accept a bundle when `ex_valid` is high.
  - LOAD: go to LOAD if `ins_type` is LOAD.
  - STORE: go to STORE if `ins_type` is SAVE.
  - Non-memory instructions stay in IDLE and produce write-back directly.
- Accept: on the edge where `ex_valid` and `in_ready` are both high, the stage registers `ins_type`, `ins_details`, `rd_addr`, `mem_addr` and `mem_val`. It sets N from the size field and clears the byte counter k.
- Non-memory:
  - On the accept edge: `wb_valid` <= 1, `wb_rd_addr` <= `rd_addr`, `wb_rd_val` <= `rd_val`.
- LOAD, per byte k = 0..N-1:
  - Present `ram_a` = `mem_addr` + k with `ram_wr` = 0.
  - Capture `ram_din` one cycle later into byte lane k. Data is little-endian: byte 0 lands in bits [7:0].
  - After the last capture, extend the value to 32 bits from bit 8N-1. Use sign-extension if `ins_details[2]` = 0, zero-extension otherwise.
  - Pulse `wb_valid` with the extended value and return to IDLE.
- STORE, per byte k = 0..N-1:
  - Present `ram_a` = `mem_addr` + k, `ram_wr` = 1, `ram_dout` = `mem_val`[8k+7:8k].
  - After the last byte, pulse `wb_valid` with `wb_rd_addr` = 0 and `wb_rd_val` = 0, then return to IDLE.
- Address arithmetic wraps modulo 2^32 before truncation to RAM_ADDR_W. Misaligned accesses are legal and need no special case.
- Loads with `rd_addr` = 0 still perform the full RAM access. Write-back reports register 0.
- When not accessing, `ram_a` = 0, `ram_wr` = 0, `ram_dout` = 0.
- `ex_valid` while `in_ready` = 0 is ignored. Upstream must hold the bundle.

## Timing
- Reset (`rst_in` low, asynchronous): state IDLE; `in_ready` = 1; `wb_valid` = 0; `wb_rd_addr` = 0; `wb_rd_val` = 0; `ram_a` = 0; `ram_wr` = 0; `ram_dout` = 0.
- Reset mid-access abandons the access; bytes already written by a store stay written. No `wb_valid` is produced.
- Cycle numbering: let the accept edge end cycle 0.
- Non-memory: `wb_valid` high in cycle 1. `in_ready` stays high, giving back-to-back throughput of 1 instruction per cycle.
- LOAD:
  - Address k is driven in cycle 1+k.
  - Data k is sampled at the end of cycle 2+k.
  - `wb_valid` is high in cycle N+2, and `in_ready` returns high in cycle N+2.
  - Latency is 3 cycles for 1 byte and 6 for 4 bytes.
- STORE:
  - Write k is driven in cycle 1+k.
  - `wb_valid` and `in_ready` are high in cycle N+1.
- `wb_valid` is a single-cycle pulse per instruction. It is never asserted for ignored bundles.
- `in_ready` is low from cycle 1 until the cycle `wb_valid` rises.

## Test plan
- Reset held low with `ram_din` = 8'hFF -> all outputs 0 and `in_ready` = 1. Assert reset in cycle 3 of an LW -> outputs clear immediately and no `wb_valid` is produced.
- Non-memory bundle `rd_addr` = 5, `rd_val` = 32'h1234_5678, followed by a second bundle the next cycle -> `wb_valid` high in cycles 1 and 2 with matching values, and `in_ready` never drops.
- LW at 32'h100, RAM bytes 78, 56, 34, 12 -> `ram_a` = 100..103 in cycles 1..4, `wb_rd_val` = 32'h1234_5678 in cycle 6.
- LB vs LBU at 32'h200 with byte 8'h80 -> 32'hFFFF_FF80 vs 32'h0000_0080 in cycle 3. LH with bytes 34, F2 -> 32'hFFFF_F234.
- SH of `mem_val` = 32'hAABB_CCDD at 32'hFFFF_FFFF -> writes DD at FFFF_FFFF and CC at 0000_0000 (wrap). `wb_valid` high in cycle 3 with `wb_rd_addr` = 0.
- SW at an odd address 32'h301, `ex_valid` held high throughout -> the second bundle is not accepted until cycle 5. Bytes are written to 301..304 little-endian.
